// File: rtl/out_port_buffered.sv
// Buffered output port: a display register fed by a small FIFO, drained by a
// slow consumer through a valid/ready handshake.
module out_port_buffered #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [WIDTH-1:0] out_port_load,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_port_out,
    output logic             out_valid,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    input  logic             ovf_clr
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    logic             free;
    logic             pop;
    logic             bypass;
    logic             push_req;
    logic             push;
    logic             drop;
    logic [CW-1:0]    count_next;

    // The display register takes the FIFO head first; bypass only when the
    // FIFO is empty, so words always leave in write order.
    always_comb begin
        free       = ~out_valid | out_ready;
        pop        = free & ~empty;
        bypass     = free & empty & load_en;
        push_req   = load_en & ~bypass;
        push       = push_req & (~full | pop);
        drop       = push_req & full & ~pop;
        count_next = count + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_port_out <= '0;
            out_valid    <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            overflow     <= 1'b0;
        end else begin
            if (pop) begin
                out_port_out <= mem[rd_ptr];
                out_valid    <= 1'b1;
                rd_ptr       <= rd_ptr + AW'(1);
            end else if (bypass) begin
                out_port_out <= out_port_load;
                out_valid    <= 1'b1;
            end else if (free) begin
                out_valid    <= 1'b0;
            end

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end

            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);

            // A drop in the same cycle as a clear wins, so no drop goes unseen.
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= out_port_load;
        end
    end

endmodule

// File: tb/tb_out_port_buffered.sv
// Directed self-checking bench for out_port_buffered (WIDTH=8, DEPTH=4).
module tb_out_port_buffered;

    logic       clk;
    logic       rst;
    logic       load_en;
    logic [7:0] out_port_load;
    logic       out_ready;
    logic [7:0] out_port_out;
    logic       out_valid;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       overflow;
    logic       ovf_clr;

    int total;
    int bad;

    out_port_buffered #(.WIDTH(8), .DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .load_en       (load_en),
        .out_port_load (out_port_load),
        .out_ready     (out_ready),
        .out_port_out  (out_port_out),
        .out_valid     (out_valid),
        .full          (full),
        .empty         (empty),
        .count         (count),
        .overflow      (overflow),
        .ovf_clr       (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then let one rising edge pass and settle.
    task automatic applyStimulus(input logic ld, input logic [7:0] data,
                                 input logic rdy, input logic clr);
        load_en       = ld;
        out_port_load = data;
        out_ready     = rdy;
        ovf_clr       = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] exp_out,
                               input logic exp_valid, input logic [2:0] exp_count,
                               input logic exp_ovf);
        logic exp_full;
        logic exp_empty;
        exp_full  = (exp_count == 3'd4);
        exp_empty = (exp_count == 3'd0);
        total++;
        assert (out_port_out === exp_out) else begin
            bad++;
            $error("[TB] FAIL %s out_port_out: got %h want %h", tag, out_port_out, exp_out);
        end
        total++;
        assert (out_valid === exp_valid) else begin
            bad++;
            $error("[TB] FAIL %s out_valid: got %b want %b", tag, out_valid, exp_valid);
        end
        total++;
        assert (count === exp_count) else begin
            bad++;
            $error("[TB] FAIL %s count: got %0d want %0d", tag, count, exp_count);
        end
        total++;
        assert (full === exp_full) else begin
            bad++;
            $error("[TB] FAIL %s full: got %b want %b", tag, full, exp_full);
        end
        total++;
        assert (empty === exp_empty) else begin
            bad++;
            $error("[TB] FAIL %s empty: got %b want %b", tag, empty, exp_empty);
        end
        total++;
        assert (overflow === exp_ovf) else begin
            bad++;
            $error("[TB] FAIL %s overflow: got %b want %b", tag, overflow, exp_ovf);
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        load_en       = 1'b0;
        out_port_load = 8'h00;
        out_ready     = 1'b0;
        ovf_clr       = 1'b0;

        // Reset and idle
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("reset_idle", 8'h00, 1'b0, 3'd0, 1'b0);

        // Bypass into an idle block, hold while not ready, then accept
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        checkOutput("bypass", 8'hA5, 1'b1, 3'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
            checkOutput("bypass_hold", 8'hA5, 1'b1, 3'd0, 1'b0);
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("bypass_accept", 8'hA5, 1'b0, 3'd0, 1'b0);

        // Fill the FIFO and drop one word
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
        end
        checkOutput("fill_full", 8'h01, 1'b1, 3'd4, 1'b1);
        for (int i = 2; i <= 5; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput("fill_drain", 8'(i), 1'b1, 3'(5 - i), 1'b1);
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("fill_idle", 8'h05, 1'b0, 3'd0, 1'b1);

        // Clear overflow, refill, then push and pop together while full
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("ovf_clear", 8'h05, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'h21 + 8'(i), 1'b0, 1'b0);
        end
        checkOutput("refill_full", 8'h21, 1'b1, 3'd4, 1'b0);
        applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
        checkOutput("pushpop_full", 8'h22, 1'b1, 3'd4, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("pushpop_d23", 8'h23, 1'b1, 3'd3, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("pushpop_d24", 8'h24, 1'b1, 3'd2, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("pushpop_d25", 8'h25, 1'b1, 3'd1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("pushpop_d77", 8'h77, 1'b1, 3'd0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("pushpop_idle", 8'h77, 1'b0, 3'd0, 1'b0);

        // Streaming at one word per cycle
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'h10 + 8'(i), 1'b1, 1'b0);
            checkOutput("stream", 8'h10 + 8'(i), 1'b1, 3'd0, 1'b0);
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("stream_idle", 8'h1F, 1'b0, 3'd0, 1'b0);

        // Overflow set/clear races, then reset mid-stream
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 8'h31 + 8'(i), 1'b0, 1'b0);
        end
        checkOutput("ovf_set", 8'h31, 1'b1, 3'd4, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("ovf_pulse_clr", 8'h31, 1'b1, 3'd4, 1'b0);
        applyStimulus(1'b1, 8'h37, 1'b0, 1'b1);
        checkOutput("ovf_set_wins", 8'h31, 1'b1, 3'd4, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("pre_reset", 8'h32, 1'b1, 3'd3, 1'b1);
        rst = 1'b1;
        applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0);
        checkOutput("mid_reset", 8'h00, 1'b0, 3'd0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput("post_reset", 8'h00, 1'b0, 3'd0, 1'b0);
        end
        applyStimulus(1'b1, 8'h40, 1'b1, 1'b0);
        checkOutput("post_reset_write", 8'h40, 1'b1, 3'd0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("post_reset_idle", 8'h40, 1'b0, 3'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
